// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selectors, FSM state encodings and
// elaboration-time helpers. The transmitter uses it now; the receiver will reuse it.
package uart_pkg;

  // Parity selector values for the PARITY parameter
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Frame FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // clk cycles per bit period
  function automatic int uart_div(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int uart_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// In-domain bit timer: counts 0..DIV-1 while enabled and flags the last cycle
// of each bit period, so every bit lasts exactly DIV clk cycles.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = uart_cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign bit_end = en && (cnt_reg == LAST);

  // Next count: wrap at the end of a bit, hold at zero while idle or restarting
  always_comb begin
    cnt_next = cnt_reg;
    if (clr || !en || bit_end) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO (valid/ready), optional even/odd parity
// and one or two stop bits. Everything runs on clk; bit timing comes from
// uart_baud_gen. Frames queued in the FIFO are sent back to back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          line,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = uart_div(CLK_FREQ, BAUDRATE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic          STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  // Reject parameter sets the frame logic cannot honour
  generate
    if (DIV < 2) begin : g_err_div
      $error("uart_tx_fifo: CLK_FREQ/BAUDRATE must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_err_width
      $error("uart_tx_fifo: DATA_WIDTH must be 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_err_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end
  endgenerate

  // ---------------- input FIFO ----------------
  // Tiny queue: plain register array with combinational head read so the FSM
  // can latch the head word on the same edge it pops it.
  logic [DATA_WIDTH-1:0] mem_reg [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [AW:0]           count_reg;
  logic [AW:0]           count_next;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_word;
  logic                  head_parity;

  assign full      = (count_reg == FULL_COUNT);
  assign empty     = (count_reg == '0);
  assign push      = tx_valid && !full;
  assign head_word = mem_reg[rd_ptr_reg];
  // Odd selector inverts the XOR; the even form is also harmless when parity is off
  assign head_parity = (PARITY == PARITY_ODD) ? ~^head_word : ^head_word;

  // Occupancy update; simultaneous push and pop leave it unchanged
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage write; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= tx_data;
    end
  end

  // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // ---------------- bit timer ----------------
  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic       bit_end;
  logic       baud_clr;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_reg != ST_IDLE),
    .clr     (baud_clr),
    .bit_end (bit_end)
  );

  // ---------------- frame FSM ----------------
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  par_reg;
  logic                  par_next;
  logic [BW-1:0]         bit_cnt_reg;
  logic [BW-1:0]         bit_cnt_next;
  logic                  stop_cnt_reg;
  logic                  stop_cnt_next;
  logic                  line_reg;
  logic                  line_next;

  // Next-state logic; a frame start (from IDLE or straight out of STOP) pops the
  // head word, latches it with its parity and drives the start bit
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    par_next      = par_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    line_next     = line_reg;
    pop           = 1'b0;
    baud_clr      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        line_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          baud_clr   = 1'b1;
          shift_next = head_word;
          par_next   = head_parity;
          line_next  = 1'b0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          line_next    = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_cnt_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_reg == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              line_next  = par_reg;
              state_next = ST_PARITY;
            end else begin
              line_next     = 1'b1;
              stop_cnt_next = 1'b0;
              state_next    = ST_STOP;
            end
          end else begin
            line_next    = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          line_next     = 1'b1;
          stop_cnt_next = 1'b0;
          state_next    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt_reg == STOP_LAST) begin
            if (!empty) begin
              pop        = 1'b1;
              baud_clr   = 1'b1;
              shift_next = head_word;
              par_next   = head_parity;
              line_next  = 1'b0;
              state_next = ST_START;
            end else begin
              line_next  = 1'b1;
              state_next = ST_IDLE;
            end
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        line_next  = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers; reset forces the line idle and aborts any frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      line_reg     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      par_reg      <= par_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      line_reg     <= line_next;
    end
  end

  assign tx_ready   = !full;
  assign line       = line_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances cover 8N1, 8E2, 8O1 and 7O1 at
// DIV=16. Stimulus queues the hand-written frame it expects for each word;
// a monitor watching the selected instance pops and checks every line cycle.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] tx_data;
  logic       tx_valid;
  int         sel;
  int         cyc = 0;

  logic       v0, v1, v2, v3;
  logic       ready0, ready1, ready2, ready3;
  logic       line0, line1, line2, line3;
  logic       busy0, busy1, busy2, busy3;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;
  logic       cur_ready, cur_line, cur_busy;
  logic [2:0] cur_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  assign v0 = tx_valid && (sel == 0);
  assign v1 = tx_valid && (sel == 1);
  assign v2 = tx_valid && (sel == 2);
  assign v3 = tx_valid && (sel == 3);

  uart_tx_fifo #(.CLK_FREQ(16), .BAUDRATE(1), .DATA_WIDTH(8), .PARITY(PARITY_NONE),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_valid(v0), .tx_ready(ready0),
    .line(line0), .busy(busy0), .fifo_count(cnt0));

  uart_tx_fifo #(.CLK_FREQ(16), .BAUDRATE(1), .DATA_WIDTH(8), .PARITY(PARITY_EVEN),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_8e2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_valid(v1), .tx_ready(ready1),
    .line(line1), .busy(busy1), .fifo_count(cnt1));

  uart_tx_fifo #(.CLK_FREQ(16), .BAUDRATE(1), .DATA_WIDTH(8), .PARITY(PARITY_ODD),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_valid(v2), .tx_ready(ready2),
    .line(line2), .busy(busy2), .fifo_count(cnt2));

  uart_tx_fifo #(.CLK_FREQ(16), .BAUDRATE(1), .DATA_WIDTH(7), .PARITY(PARITY_ODD),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_7o1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_valid(v3), .tx_ready(ready3),
    .line(line3), .busy(busy3), .fifo_count(cnt3));

  always_comb begin
    cur_ready = ready0; cur_line = line0; cur_busy = busy0; cur_cnt = cnt0;
    case (sel)
      1: begin cur_ready = ready1; cur_line = line1; cur_busy = busy1; cur_cnt = cnt1; end
      2: begin cur_ready = ready2; cur_line = line2; cur_busy = busy2; cur_cnt = cnt2; end
      3: begin cur_ready = ready3; cur_line = line3; cur_busy = busy3; cur_cnt = cnt3; end
      default: ;
    endcase
  end

  // Expected frame: bits[i] is the i-th line bit (bit 0 = start bit)
  typedef struct {
    logic [15:0] bits;
    int          nbits;
    bit          b2b;
  } frame_t;

  frame_t exp_q[$];
  int     total = 0;
  int     bad = 0;
  bit     mon_in_frame = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one pass per clk, sampled on the falling edge
  initial begin : monitor
    frame_t cur;
    int     bit_idx = 0;
    int     cyc_in_bit = 0;
    int     gap = 0;
    int     frame_errs = 0;
    bit     bit_bad = 1'b0;
    bit     just_ended = 1'b0;
    logic   got_line = 1'b0;
    logic   got_busy = 1'b0;
    cur.bits = '0; cur.nbits = 0; cur.b2b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_in_frame = 1'b0;
        just_ended = 1'b0;
        gap = 0;
        continue;
      end
      if (!mon_in_frame) begin
        if (cur_line === 1'b0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: line got 0 required 1 (no word pending) dut=%0d t=%0t", sel, $time);
          end else begin
            cur = exp_q.pop_front();
            mon_in_frame = 1'b1;
            bit_idx = 0;
            cyc_in_bit = 0;
            bit_bad = 1'b0;
            frame_errs = 0;
            if (cur.b2b) check("frame_gap_cycles", gap, 0);
          end
        end else begin
          if (just_ended) check("busy_after_frame", {31'd0, cur_busy}, 0);
          gap++;
        end
        just_ended = 1'b0;
      end
      if (mon_in_frame) begin
        if ((cur_line !== cur.bits[bit_idx] || cur_busy !== 1'b1) && !bit_bad) begin
          bit_bad = 1'b1;
          got_line = cur_line;
          got_busy = cur_busy;
        end
        cyc_in_bit++;
        if (cyc_in_bit == 16) begin
          total++;
          if (bit_bad) begin
            bad++;
            frame_errs++;
            $display("FAIL frame_bit[%0d]: line/busy got %b/%b required %b/1 dut=%0d t=%0t",
                     bit_idx, got_line, got_busy, cur.bits[bit_idx], sel, $time);
          end
          bit_idx++;
          cyc_in_bit = 0;
          bit_bad = 1'b0;
          if (bit_idx == cur.nbits) begin
            $display("txn: dut=%0d frame of %0d bits ended t=%0t, bit errors=%0d",
                     sel, cur.nbits, $time, frame_errs);
            mon_in_frame = 1'b0;
            just_ended = 1'b1;
            gap = 0;
          end
        end
      end
    end
  end

  // Offer one word (valid stays high on return) and queue its expected frame
  task automatic send(input logic [8:0] w, input logic [15:0] bits, input int nbits,
                      input bit b2b, input bit expect_frame, output int acc_cyc);
    frame_t f;
    tx_data = w;
    tx_valid = 1'b1;
    for (int k = 0; k < 1000 && cur_ready !== 1'b1; k++) @(negedge clk);
    if (cur_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_timeout: tx_ready got 0 required 1 within 1000 clk, word %0h", w);
      acc_cyc = -1;
      return;
    end
    if (expect_frame) begin
      f.bits = bits; f.nbits = nbits; f.b2b = b2b;
      exp_q.push_back(f);
    end
    @(posedge clk);
    #1 acc_cyc = cyc;
    $display("txn: dut=%0d word %0h accepted at cycle %0d", sel, w, acc_cyc);
    @(negedge clk);
  endtask

  task automatic wait_done(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      if (exp_q.size() == 0 && !mon_in_frame) break;
      @(negedge clk);
    end
    if (k == limit) begin
      total++;
      bad++;
      $display("FAIL wait_done: %0d frames still pending after %0d clk", exp_q.size(), limit);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int acc [6];
    int a0;
    logic [7:0] w_tab [6];
    w_tab[0] = 8'h11; w_tab[1] = 8'h22; w_tab[2] = 8'h33;
    w_tab[3] = 8'h44; w_tab[4] = 8'h55; w_tab[5] = 8'h66;

    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    sel = 0;

    // 1: reset state, then quiet release
    repeat (4) @(negedge clk);
    check("rst_line", {31'd0, line0}, 1);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_tx_ready", {31'd0, ready0}, 1);
    check("rst_fifo_count", {29'd0, cnt0}, 0);
    check("rst_line_7o1", {31'd0, line3}, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_line", {31'd0, line0}, 1);
    check("idle_busy", {31'd0, busy0}, 0);
    check("idle_fifo_count", {29'd0, cnt0}, 0);

    // 2: 8N1 0xA5 with first-bit latency
    sel = 0;
    send(9'h0A5, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 1'b1, a0);
    tx_valid = 1'b0;
    check("lat_line_edgeN", {31'd0, line0}, 1);
    check("lat_busy_edgeN", {31'd0, busy0}, 0);
    check("lat_count_edgeN", {29'd0, cnt0}, 1);
    @(negedge clk);
    check("lat_line_edgeN1", {31'd0, line0}, 0);
    check("lat_busy_edgeN1", {31'd0, busy0}, 1);
    check("lat_count_edgeN1", {29'd0, cnt0}, 0);
    wait_done(400);

    // 3: 8E2 and 8O1 with 0x07
    sel = 1;
    send(9'h007, {4'd0, 2'b11, 1'b1, 8'h07, 1'b0}, 12, 1'b0, 1'b1, a0);
    tx_valid = 1'b0;
    wait_done(400);
    sel = 2;
    send(9'h007, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0, 1'b1, a0);
    tx_valid = 1'b0;
    wait_done(400);

    // 4: six words with valid held; FIFO fills, frames run back to back
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      send({1'b0, w_tab[i]}, {6'd0, 1'b1, w_tab[i], 1'b0}, 10, (i > 0), 1'b1, acc[i]);
      if (i == 1) check("second_word_next_edge", acc[1] - acc[0], 1);
      if (i == 4) begin
        check("full_fifo_count", {29'd0, cnt0}, 4);
        check("full_tx_ready", {31'd0, ready0}, 0);
      end
    end
    tx_valid = 1'b0;
    check("sixth_word_after_pop", acc[5] - acc[0], 162);
    wait_done(2000);

    // 5: reset during data bit 3 with two words queued
    sel = 0;
    send(9'h000, {6'd0, 1'b1, 8'h00, 1'b0}, 10, 1'b0, 1'b1, a0);
    send(9'h0F0, '0, 0, 1'b0, 1'b0, acc[0]);
    send(9'h0F1, '0, 0, 1'b0, 1'b0, acc[1]);
    tx_valid = 1'b0;
    check("pre_abort_fifo_count", {29'd0, cnt0}, 2);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #2;
      if (cyc >= a0 + 72) break;
    end
    check("pre_abort_line_low", {31'd0, line0}, 0);
    rst_n = 1'b0;
    #1;
    check("abort_line", {31'd0, line0}, 1);
    check("abort_busy", {31'd0, busy0}, 0);
    check("abort_fifo_count", {29'd0, cnt0}, 0);
    check("abort_tx_ready", {31'd0, ready0}, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("post_abort_line", {31'd0, line0}, 1);
    check("post_abort_busy", {31'd0, busy0}, 0);
    check("post_abort_fifo_count", {29'd0, cnt0}, 0);

    // 6: 7O1 with 0x55
    sel = 3;
    send(9'h055, {6'd0, 1'b1, 1'b1, 7'h55, 1'b0}, 10, 1'b0, 1'b1, a0);
    tx_valid = 1'b0;
    wait_done(400);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
